os_combine_pipe: RTL

- Parametrised, pipelined successor of the fixed 16-bit GF(2) overlap-sum combiner. Used for carry-less Karatsuba recombination.
- Merges the low product z0, the middle product z1, the high product z2 and the overlap term o into a (2H-1)-bit result using XOR only.
- Adds a valid/ready stream interface, two register stages and an optional running XOR-accumulate mode for multi-limb products.
- Sits between the partial-product multipliers and the reduction stage.

---
 rtl/os_pkg.sv | 52 +++++
 rtl/os_pipe_reg.sv | 42 ++++
 rtl/os_combine_pipe.sv | 131 +++++++++++++
 3 files changed

// File: rtl/os_pkg.sv
// Shared types and the GF(2) overlap-sum combine function for os_combine_pipe.
//
// Contents:
//   os_mode_e   - beat mode, OS_PASS or OS_ACC
//   OS_YW/OS_OW - result and overlap widths for the default half width
//   os_yw/os_ow - width helpers for any half width h
//   os_combine  - merges z0, z1, z2 and o with XOR only. It works on MAX_H-wide
//                 containers; callers zero-extend the inputs and truncate the
//                 result to 2h-1 bits.
package os_pkg;

    typedef enum logic {
        OS_PASS = 1'b0,
        OS_ACC  = 1'b1
    } os_mode_e;

    localparam int unsigned H_DEF = 8;
    localparam int unsigned OS_YW = 2 * H_DEF - 1;
    localparam int unsigned OS_OW = H_DEF - 1;

    // Largest half width os_combine supports.
    localparam int unsigned MAX_H = 32;

    function automatic int unsigned os_yw(input int unsigned h);
        return 2 * h - 1;
    endfunction

    function automatic int unsigned os_ow(input int unsigned h);
        return h - 1;
    endfunction

    function automatic logic [2*MAX_H-2:0] os_combine(
        input int unsigned        h,
        input logic [MAX_H-1:0]   z0,
        input logic [2*MAX_H-2:0] z1,
        input logic [MAX_H-1:0]   z2,
        input logic [MAX_H-2:0]   o
    );
        logic [2*MAX_H-2:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_H - 1; i++) begin
            if (i + 1 < h) begin
                r[i]     = z1[i] ^ z0[i] ^ o[i];
                r[h + i] = z1[h + i] ^ z2[i + 1] ^ o[i];
            end
        end
        // The seam bit is the only place z2 and z0 overlap.
        r[h - 1] = z2[0] ^ z1[h - 1] ^ z0[h - 1];
        return r;
    endfunction

endpackage

// File: rtl/os_pipe_reg.sv
// Single valid/ready register slice (no skid buffer).
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid / in_ready - upstream handshake
//   in_data             - upstream payload, W bits
//   out_valid/out_ready - downstream handshake
//   out_data            - registered payload, W bits
module os_pipe_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         vld_q;
    logic [W-1:0] data_q;

    // Accept when empty or when the held beat leaves on this same edge.
    assign in_ready  = !vld_q || out_ready;
    assign out_valid = vld_q;
    assign out_data  = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else if (in_valid && in_ready) begin
            vld_q  <= 1'b1;
            data_q <= in_data;
        end else if (out_ready) begin
            vld_q  <= 1'b0;
        end
    end

endmodule

// File: rtl/os_combine_pipe.sv
// Pipelined GF(2) overlap-sum combiner for carry-less Karatsuba recombination.
// Stage A registers the input beat, stage B registers the combined result and
// optionally XOR-accumulates it across beats for multi-limb products.
//
// Parameters:
//   H       - half width (2 <= H <= os_pkg::MAX_H)
//   ACC_RST - reset and clear value of the accumulator
//
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid / in_ready  - input handshake
//   z0, z1, z2, o        - low, middle and high products, overlap term
//   mode                 - 0 = PASS, 1 = ACC, captured with the beat
//   acc_clr              - synchronous accumulator clear
//   out_valid/out_ready  - output handshake
//   y                    - result, 2H-1 bits
//   y_par, par_err       - only with OS_PARITY_EN: parity of y, and a
//                          one-cycle self-check flag on a stage-B load
module os_combine_pipe
    import os_pkg::*;
#(
    parameter int unsigned    H       = 8,
    parameter logic [2*H-2:0] ACC_RST = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [H-1:0]   z0,
    input  logic [2*H-2:0] z1,
    input  logic [H-1:0]   z2,
    input  logic [H-2:0]   o,
    input  logic           mode,
    input  logic           acc_clr,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*H-2:0] y
`ifdef OS_PARITY_EN
    ,
    output logic           y_par,
    output logic           par_err
`endif
);

    localparam int unsigned YW = 2 * H - 1;
    localparam int unsigned OW = H - 1;
    localparam int unsigned AW = 1 + OW + H + YW + H;

    logic          a_vld;
    logic [AW-1:0] a_data;
    logic [H-1:0]  a_z0, a_z2;
    logic [YW-1:0] a_z1;
    logic [OW-1:0] a_o;
    logic          a_mode;

    logic          b_free, b_load, acc_load;
    logic          out_valid_q;
    logic [YW-1:0] y_q, acc_q, acc_eff, f, y_d;

    assign b_free = !out_valid_q || out_ready;

    os_pipe_reg #(
        .W (AW)
    ) u_stage_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({mode, o, z2, z1, z0}),
        .out_valid (a_vld),
        .out_ready (b_free),
        .out_data  (a_data)
    );

    assign {a_mode, a_o, a_z2, a_z1, a_z0} = a_data;

    assign f = YW'(os_combine(H, MAX_H'(a_z0), (2*MAX_H-1)'(a_z1), MAX_H'(a_z2),
                              (MAX_H-1)'(a_o)));

    assign b_load   = a_vld && b_free;
    assign acc_load = b_load && (os_mode_e'(a_mode) == OS_ACC);

    // A clear on the same edge as an ACC load restarts the sum from ACC_RST.
    assign acc_eff = acc_clr ? ACC_RST : acc_q;
    assign y_d     = (os_mode_e'(a_mode) == OS_ACC) ? (f ^ acc_eff) : f;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            acc_q       <= ACC_RST;
        end else begin
            if (b_load) begin
                out_valid_q <= 1'b1;
                y_q         <= y_d;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (acc_load) begin
                acc_q <= y_d;
            end else if (acc_clr) begin
                acc_q <= ACC_RST;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;

`ifdef OS_PARITY_EN
    logic y_par_q, par_err_q;

    // o lands on two result bits, so it cancels out of the parity of f.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_par_q   <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= b_load && ((^f) != ((^a_z0) ^ (^a_z1) ^ (^a_z2)));
            if (b_load) begin
                y_par_q <= ^y_d;
            end
        end
    end

    assign y_par   = y_par_q;
    assign par_err = par_err_q;
`endif

endmodule
